eeprom_arbiter: RTL

- Shares the single-port save EEPROM RAM (8 KiB, synchronous read) between two requesters: the I2C protocol engine and the host save-file port (image load/save over the frontend).
- Round-robin arbitration; host lock for exclusive image load; one transaction at a time.
- Tracks a dirty flag so the frontend knows when the save image must be written back.

---
 rtl/eeprom_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/eeprom_arbiter.sv
// Shares the single-port save EEPROM RAM between the I2C engine and the host save-file port.
// Uses round-robin arbitration with a host exclusive lock, and tracks a dirty flag for write-back.
module eeprom_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  input  logic              dirty_clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dirty,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_e;
  typedef enum logic {GNT_I2C, GNT_HOST} grant_e;

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;  // last winner; also owns the transaction while busy
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              i2c_ack_q, i2c_ack_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              dirty_q, dirty_d;

  logic i2c_elig, host_elig, pick_host, pick_we, i2c_wr_strobe;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 1'b0;
    i2c_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    i2c_rdata_d  = i2c_rdata_q;
    host_rdata_d = host_rdata_q;

    i2c_elig  = i2c_req && !host_lock;
    host_elig = host_req;
    // Host wins when it is the only eligible side, or on a tie after an I2C grant.
    pick_host = host_elig && (!i2c_elig || grant_q == GNT_I2C);
    pick_we   = pick_host ? host_we : i2c_we;

    case (state_q)
      IDLE: begin
        if (i2c_elig || host_elig) begin
          state_d     = ACCESS;
          grant_d     = pick_host ? GNT_HOST : GNT_I2C;
          ram_addr_d  = pick_host ? host_addr : i2c_addr;
          ram_wdata_d = pick_host ? host_wdata : i2c_wdata;
          ram_we_d    = pick_we;
          // A write completes in the ACCESS cycle, so its ack is registered with the strobe.
          i2c_ack_d   = pick_we && !pick_host;
          host_ack_d  = pick_we && pick_host;
        end
      end
      ACCESS: state_d = ram_we_q ? IDLE : RDWAIT;
      RDWAIT: begin
        state_d = DONE;
        if (grant_q == GNT_HOST) begin
          host_rdata_d = ram_rdata;
          host_ack_d   = 1'b1;
        end else begin
          i2c_rdata_d = ram_rdata;
          i2c_ack_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    i2c_wr_strobe = (state_q == ACCESS) && ram_we_q && (grant_q == GNT_I2C);
    // Set beats a coincident clear so a save cannot silently lose a fresh write.
    dirty_d = i2c_wr_strobe || (dirty_q && !dirty_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= GNT_HOST;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      i2c_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      i2c_rdata_q  <= '0;
      host_rdata_q <= '0;
      dirty_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      i2c_ack_q    <= i2c_ack_d;
      host_ack_q   <= host_ack_d;
      i2c_rdata_q  <= i2c_rdata_d;
      host_rdata_q <= host_rdata_d;
      dirty_q      <= dirty_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign i2c_ack    = i2c_ack_q;
  assign host_ack   = host_ack_q;
  assign i2c_rdata  = i2c_rdata_q;
  assign host_rdata = host_rdata_q;
  assign dirty      = dirty_q;
  assign busy       = (state_q != IDLE);

endmodule
